// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch display path:
//   - status encodings coming from the stopwatch core
//   - BCD converter state encodings
//   - active-high 7-segment glyphs, bit order {g,f,e,d,c,b,a}
//   - helpers for the shift-add-3 step and the digit-to-glyph lookup
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_INVALID = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    C_IDLE   = 2'b00,
    C_LOAD   = 2'b01,
    C_SHIFT  = 2'b10,
    C_UPDATE = 2'b11
  } conv_state_e;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  localparam logic [7:0] MIN_MAX = 8'd99;
  localparam logic [5:0] SEC_MAX = 6'd59;

  // Nibble correction applied before each shift of the double-dabble.
  function automatic logic [3:0] add3_ge5(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // One iteration on {tens, units, binary}: correct both BCD nibbles, shift left.
  function automatic logic [15:0] dabble_step(input logic [15:0] v);
    logic [15:0] t;
    t = {add3_ge5(v[15:12]), add3_ge5(v[11:8]), v[7:0]};
    return {t[14:0], 1'b0};
  endfunction

  // BCD digit to active-high glyph; anything outside 0..9 shows a dash.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_DASH;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bcd_conv_seq.sv
// -----------------------------------------------------------------------------
// bcd_conv_seq
// Sequential binary-to-BCD engine converting two 8-bit values (each < 100) in
// parallel with the shift-add-3 method.
// Sequence: C_IDLE -> C_LOAD -> C_SHIFT x8 -> C_UPDATE -> C_IDLE.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start_i             request a conversion (honoured only in C_IDLE)
//   bin_a_i, bin_b_i    binaries, captured during C_LOAD
//   busy_o              registered, high in LOAD/SHIFT/UPDATE
//   load_o              high in C_LOAD (caller snapshots its own context)
//   done_o              high in C_UPDATE, digits valid this cycle
//   a/b_tens_o/units_o  BCD result nibbles
// -----------------------------------------------------------------------------
module bcd_conv_seq
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] bin_a_i,
  input  logic [7:0] bin_b_i,
  output logic       busy_o,
  output logic       load_o,
  output logic       done_o,
  output logic [3:0] a_tens_o,
  output logic [3:0] a_units_o,
  output logic [3:0] b_tens_o,
  output logic [3:0] b_units_o
);

  conv_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] sr_a_q, sr_a_d;
  logic [15:0] sr_b_q, sr_b_d;
  logic        busy_q, busy_d;

  // Next-state and datapath for the converter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_a_d  = sr_a_q;
    sr_b_d  = sr_b_q;
    case (state_q)
      C_IDLE: begin
        if (start_i) begin
          state_d = C_LOAD;
        end else begin
          state_d = C_IDLE;
        end
      end
      C_LOAD: begin
        sr_a_d  = {8'h00, bin_a_i};
        sr_b_d  = {8'h00, bin_b_i};
        cnt_d   = 3'd0;
        state_d = C_SHIFT;
      end
      C_SHIFT: begin
        sr_a_d = dabble_step(sr_a_q);
        sr_b_d = dabble_step(sr_b_q);
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = C_UPDATE;
        end else begin
          state_d = C_SHIFT;
        end
      end
      C_UPDATE: begin
        state_d = C_IDLE;
      end
      default: begin
        state_d = C_IDLE;
      end
    endcase
    busy_d = (state_d != C_IDLE);
  end

  // Converter state register; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= C_IDLE;
      cnt_q   <= 3'd0;
      sr_a_q  <= 16'h0000;
      sr_b_q  <= 16'h0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_a_q  <= sr_a_d;
      sr_b_q  <= sr_b_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o    = busy_q;
  assign load_o    = (state_q == C_LOAD);
  assign done_o    = (state_q == C_UPDATE);
  assign a_tens_o  = sr_a_q[15:12];
  assign a_units_o = sr_a_q[11:8];
  assign b_tens_o  = sr_b_q[15:12];
  assign b_units_o = sr_b_q[11:8];

endmodule

// File: rtl/stopwatch_display_driver.sv
// -----------------------------------------------------------------------------
// stopwatch_display_driver
// Shows the stopwatch time as MM.SS on a 4-digit multiplexed 7-segment display.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   minutes      binary minutes (values above 99 display as 99)
//   seconds      binary seconds (values above 59 display the seconds as dashes)
//   status       00 idle, 01 running, 10 paused (blinks), 11 invalid (all dashes)
//   seg          registered segments {g,f,e,d,c,b,a}
//   dp           registered decimal point, lit on the minutes-units digit
//   an           registered one-hot digit select, an[3]=min tens .. an[0]=sec units
//   conv_busy    high while the BCD converter is working
// Polarity of seg/dp/an is set by SEG_ACTIVE_LOW.
// -----------------------------------------------------------------------------
module stopwatch_display_driver
  import stopwatch_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int BLINK_DIV      = 12500000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] minutes,
  input  logic [5:0] seconds,
  input  logic [1:0] status,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       conv_busy
);

  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = $clog2(BLINK_DIV);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [3:0] AN_OFF  = SEG_ACTIVE_LOW ? 4'hF : 4'h0;

  // Converter interface
  logic       start_s, load_s, done_s;
  logic [7:0] min_clamped_s;
  logic [3:0] mt_s, mu_s, st_s, su_s;

  // Snapshot of the last converted input and the displayed value
  logic [13:0] snap_q;
  logic        dash_pend_q;
  logic [15:0] disp_q;       // {min tens, min units, sec tens, sec units}
  logic        dash_q;

  // Scan and blink timing
  logic [REF_W-1:0] ref_q, ref_d;
  logic [1:0]       idx_q, idx_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic             phase_q, phase_d;
  status_e          status_q;

  // Digit encode and output registers
  logic [6:0] digit_seg_s, seg_h_s, seg_d, seg_q;
  logic       digit_dp_s, dp_h_s, dp_d, dp_q;
  logic [3:0] an_h_s, an_d, an_q;

  // The snapshot holds the raw inputs, so an out-of-range value that clamps to
  // the same display still counts as a change and is reconverted harmlessly.
  assign start_s       = ({minutes, seconds} != snap_q);
  assign min_clamped_s = (minutes > MIN_MAX) ? MIN_MAX : minutes;

  bcd_conv_seq u_conv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_s),
    .bin_a_i   (min_clamped_s),
    .bin_b_i   ({2'b00, seconds}),
    .busy_o    (conv_busy),
    .load_o    (load_s),
    .done_o    (done_s),
    .a_tens_o  (mt_s),
    .a_units_o (mu_s),
    .b_tens_o  (st_s),
    .b_units_o (su_s)
  );

  // Snapshot in LOAD (same cycle the converter captures), commit in UPDATE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_q      <= 14'h0000;
      dash_pend_q <= 1'b0;
      disp_q      <= 16'h0000;
      dash_q      <= 1'b0;
    end else begin
      if (load_s) begin
        snap_q      <= {minutes, seconds};
        dash_pend_q <= (seconds > SEC_MAX);
      end
      if (done_s) begin
        disp_q <= {mt_s, mu_s, st_s, su_s};
        dash_q <= dash_pend_q;
      end
    end
  end

  // Free-running refresh and blink counters.
  always_comb begin
    ref_d   = ref_q + REF_W'(1);
    idx_d   = idx_q;
    blk_d   = blk_q + BLK_W'(1);
    phase_d = phase_q;
    if (ref_q == REF_LAST) begin
      ref_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      idx_d = idx_q;
    end
    if (blk_q == BLK_LAST) begin
      blk_d   = '0;
      phase_d = ~phase_q;
    end else begin
      phase_d = phase_q;
    end
  end

  // Digit glyph selection, overrides for invalid status and pause blanking.
  always_comb begin
    digit_seg_s = SEG_DASH;
    digit_dp_s  = 1'b0;
    case (idx_q)
      2'd3: digit_seg_s = glyph(disp_q[15:12]);
      2'd2: begin
        digit_seg_s = glyph(disp_q[11:8]);
        digit_dp_s  = 1'b1;
      end
      2'd1: digit_seg_s = dash_q ? SEG_DASH : glyph(disp_q[7:4]);
      2'd0: digit_seg_s = dash_q ? SEG_DASH : glyph(disp_q[3:0]);
      default: digit_seg_s = SEG_DASH;
    endcase

    if (status_q == ST_INVALID) begin
      seg_h_s = SEG_DASH;
      dp_h_s  = 1'b0;
    end else begin
      seg_h_s = digit_seg_s;
      dp_h_s  = digit_dp_s;
    end

    if ((status_q == ST_PAUSED) && phase_q) begin
      an_h_s = 4'b0000;
    end else begin
      an_h_s = 4'b0001 << idx_q;
    end

    if (SEG_ACTIVE_LOW) begin
      seg_d = ~seg_h_s;
      dp_d  = ~dp_h_s;
      an_d  = ~an_h_s;
    end else begin
      seg_d = seg_h_s;
      dp_d  = dp_h_s;
      an_d  = an_h_s;
    end
  end

  // Timing registers, sampled status and the pin-facing output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_q    <= '0;
      idx_q    <= 2'd0;
      blk_q    <= '0;
      phase_q  <= 1'b0;
      status_q <= ST_IDLE;
      seg_q    <= SEG_OFF;
      dp_q     <= DP_OFF;
      an_q     <= AN_OFF;
    end else begin
      ref_q    <= ref_d;
      idx_q    <= idx_d;
      blk_q    <= blk_d;
      phase_q  <= phase_d;
      status_q <= status_e'(status);
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_stopwatch_display_driver.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_display_driver
// Randomized and directed checks of the display driver against a time-based
// reference: expected pin state is derived from the number of clock edges since
// reset release and the displayed MM:SS value using plain arithmetic.
// -----------------------------------------------------------------------------
module tb_stopwatch_display_driver;

  localparam logic [6:0] GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       clk;
  logic       rst_n;
  logic [7:0] minutes;
  logic [5:0] seconds;
  logic [1:0] status;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       conv_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // edges since reset release (first edge with rst_n high = 1)

  stopwatch_display_driver #(
    .REFRESH_DIV    (4),
    .BLINK_DIV      (8),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .minutes   (minutes),
    .seconds   (seconds),
    .status    (status),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .conv_busy (conv_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected active-low pins after edge k for a displayed time and stable status.
  function automatic void model(input int k, input int mn, input int sc, input int st,
                                output logic [3:0] an_e, output logic [6:0] seg_e,
                                output logic dp_e, output bit care);
    int idx, ph, mc;
    int d[4];
    logic [3:0] an_h;
    logic [6:0] seg_h;
    logic       dp_h;
    idx  = ((k - 1) / 4) % 4;
    ph   = ((k - 1) / 8) % 2;
    mc   = (mn > 99) ? 99 : mn;
    d[3] = mc / 10;
    d[2] = mc % 10;
    d[1] = sc / 10;
    d[0] = sc % 10;
    an_h = 4'b0000;
    an_h[idx] = 1'b1;
    if (st == 2 && ph == 1) an_h = 4'b0000;
    care = (an_h != 4'b0000);
    if (st == 3) begin
      seg_h = 7'h40;
      dp_h  = 1'b0;
    end else begin
      seg_h = (idx < 2 && sc > 59) ? 7'h40 : GLYPH[d[idx]];
      dp_h  = (idx == 2);
    end
    an_e  = ~an_h;
    seg_e = ~seg_h;
    dp_e  = ~dp_h;
  endfunction

  task automatic set_inputs(input int mn, input int sc, input int st);
    minutes = 8'(mn);
    seconds = 6'(sc);
    status  = 2'(st);
  endtask

  // Waits (bounded) for busy, then counts busy samples; returns on first idle sample.
  task automatic measure_busy(output int n);
    int w;
    w = 0;
    n = 0;
    while (conv_busy !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    while (conv_busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    logic [3:0] ea; logic [6:0] es; logic ed; bit care;
    set_inputs(0, 0, 0);
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got=%h exp=F", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h exp=7F", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", dp); end
    checks++; if (conv_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", conv_busy); end
    rst_n = 1'b1;
    tick();
    model(cyc, 0, 0, 0, ea, es, ed, care);
    checks++; if (an !== ea || an !== 4'hE) begin errors++; $display("FAIL first_drive_an got=%h exp=%h", an, ea); end
    checks++; if (seg !== es) begin errors++; $display("FAIL first_drive_seg got=%h exp=%h", seg, es); end
    checks++; if (conv_busy !== 1'b0) begin errors++; $display("FAIL zero_no_conv got=%b exp=0", conv_busy); end
  endtask

  task automatic test_basic();
    logic [3:0] ea; logic [6:0] es; logic ed; bit care; int n;
    set_inputs(12, 34, 1);
    measure_busy(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL basic_busy_len got=%0d exp=10", n); end
    repeat (2) tick();
    for (int i = 0; i < 16; i++) begin
      model(cyc, 12, 34, 1, ea, es, ed, care);
      checks++; if (an !== ea) begin errors++; $display("FAIL basic_an cyc=%0d got=%h exp=%h", cyc, an, ea); end
      checks++; if (seg !== es || dp !== ed) begin errors++; $display("FAIL basic_seg cyc=%0d got=%h/%b exp=%h/%b", cyc, seg, dp, es, ed); end
      tick();
    end
  endtask

  task automatic test_clamp_dash();
    logic [3:0] ea; logic [6:0] es; logic ed; bit care; int n;
    set_inputs(150, 59, 1);
    measure_busy(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL clamp_busy_len got=%0d exp=10", n); end
    repeat (2) tick();
    for (int i = 0; i < 16; i++) begin
      model(cyc, 150, 59, 1, ea, es, ed, care);
      checks++; if (an !== ea || seg !== es || dp !== ed) begin errors++; $display("FAIL clamp_scan cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc, an, seg, dp, ea, es, ed); end
      tick();
    end
    set_inputs(150, 60, 1);
    measure_busy(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL dash_busy_len got=%0d exp=10", n); end
    repeat (2) tick();
    for (int i = 0; i < 16; i++) begin
      model(cyc, 150, 60, 1, ea, es, ed, care);
      checks++; if (an !== ea || seg !== es || dp !== ed) begin errors++; $display("FAIL dash_scan cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc, an, seg, dp, ea, es, ed); end
      tick();
    end
  endtask

  task automatic test_pause_invalid();
    logic [3:0] ea; logic [6:0] es; logic ed; bit care; int blanks;
    set_inputs(150, 60, 2);
    repeat (3) tick();
    blanks = 0;
    for (int i = 0; i < 32; i++) begin
      model(cyc, 150, 60, 2, ea, es, ed, care);
      if (an === 4'hF) blanks++;
      checks++; if (an !== ea) begin errors++; $display("FAIL pause_an cyc=%0d got=%h exp=%h", cyc, an, ea); end
      if (care) begin
        checks++; if (seg !== es || dp !== ed) begin errors++; $display("FAIL pause_seg cyc=%0d got=%h/%b exp=%h/%b", cyc, seg, dp, es, ed); end
      end
      tick();
    end
    checks++; if (blanks !== 16) begin errors++; $display("FAIL pause_blank_count got=%0d exp=16", blanks); end
    set_inputs(150, 60, 3);
    repeat (3) tick();
    for (int i = 0; i < 16; i++) begin
      model(cyc, 150, 60, 3, ea, es, ed, care);
      checks++; if (an !== ea || seg !== 7'h3F || dp !== 1'b1) begin errors++; $display("FAIL invalid_scan cyc=%0d got=%h/%h/%b exp=%h/3f/1", cyc, an, seg, dp, ea); end
      tick();
    end
    set_inputs(150, 60, 1);
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] ea; logic [6:0] es; logic ed; bit care; int n, n2, w;
    set_inputs(1, 0, 1);
    w = 0; n = 0;
    while (conv_busy !== 1'b1 && w < 20) begin tick(); w++; end
    while (conv_busy === 1'b1 && n < 40) begin
      n++;
      if (n == 3) minutes = 8'd2;
      tick();
    end
    checks++; if (n !== 10) begin errors++; $display("FAIL b2b_first_len got=%0d exp=10", n); end
    tick();
    checks++; if (conv_busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got=%b exp=1", conv_busy); end
    n2 = 0;
    while (conv_busy === 1'b1 && n2 < 40) begin
      model(cyc, 1, 0, 1, ea, es, ed, care);
      checks++; if (an !== ea || seg !== es || dp !== ed) begin errors++; $display("FAIL b2b_mid_value cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc, an, seg, dp, ea, es, ed); end
      n2++;
      tick();
    end
    checks++; if (n2 !== 10) begin errors++; $display("FAIL b2b_second_len got=%0d exp=10", n2); end
    repeat (2) tick();
    for (int i = 0; i < 16; i++) begin
      model(cyc, 2, 0, 1, ea, es, ed, care);
      checks++; if (an !== ea || seg !== es || dp !== ed) begin errors++; $display("FAIL b2b_final cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc, an, seg, dp, ea, es, ed); end
      tick();
    end
  endtask

  task automatic test_reset_mid_conv();
    logic [3:0] ea; logic [6:0] es; logic ed; bit care; int n, w;
    set_inputs(7, 45, 1);
    w = 0; n = 0;
    while (conv_busy !== 1'b1 && w < 20) begin tick(); w++; end
    while (conv_busy === 1'b1 && n < 5) begin
      n++;
      if (n < 5) tick();
    end
    checks++; if (n !== 5) begin errors++; $display("FAIL midrst_reach got=%0d exp=5", n); end
    rst_n = 1'b0;
    tick();
    checks++; if (conv_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", conv_busy); end
    checks++; if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin errors++; $display("FAIL midrst_pins got=%h/%h/%b exp=f/7f/1", an, seg, dp); end
    tick();
    rst_n = 1'b1;
    measure_busy(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL midrst_reconv_len got=%0d exp=10", n); end
    repeat (2) tick();
    for (int i = 0; i < 16; i++) begin
      model(cyc, 7, 45, 1, ea, es, ed, care);
      checks++; if (an !== ea || seg !== es || dp !== ed) begin errors++; $display("FAIL midrst_scan cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc, an, seg, dp, ea, es, ed); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [3:0] ea; logic [6:0] es; logic ed; bit care; int n, mn, sc, st;
    for (int t = 0; t < 8; t++) begin
      mn = int'($urandom_range(0, 255));
      sc = int'($urandom_range(0, 63));
      st = int'($urandom_range(0, 1));
      if (mn == int'(minutes) && sc == int'(seconds)) mn = (mn + 1) % 256;
      set_inputs(mn, sc, st);
      measure_busy(n);
      checks++; if (n !== 10) begin errors++; $display("FAIL rand_busy_len t=%0d got=%0d exp=10", t, n); end
      repeat (2) tick();
      for (int i = 0; i < 16; i++) begin
        model(cyc, mn, sc, st, ea, es, ed, care);
        checks++; if (an !== ea || seg !== es || dp !== ed) begin errors++; $display("FAIL rand_scan %0d:%0d cyc=%0d got=%h/%h/%b exp=%h/%h/%b", mn, sc, cyc, an, seg, dp, ea, es, ed); end
        tick();
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_inputs(0, 0, 0);
    test_reset();
    test_basic();
    test_clamp_dash();
    test_pause_invalid();
    test_back_to_back();
    test_reset_mid_conv();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
